// File: rtl/funnel_ctrl_1_2.sv
// Wide-to-narrow serializer: one NB*DW word in, NB DW-bit beats out, LSB slice first.
// Optional FUNNEL_CTRL_LAST_EN adds i_0_last and a sticky input-stall overflow flag err_ovf.
module funnel_ctrl_1_2 #(
    parameter int unsigned DW = 32,
    parameter int unsigned NB = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             t_0_req,
    output logic             t_0_ack,
    input  logic [NB*DW-1:0] t_0_data,
    input  logic             t_cfg_req,
    output logic             t_cfg_ack,
    input  logic [7:0]       mode,
    output logic             i_0_req,
    input  logic             i_0_ack,
    output logic [DW-1:0]    i_0_data,
    output logic [NB-1:0]    enable
`ifdef FUNNEL_CTRL_LAST_EN
    ,
    output logic             i_0_last,
    output logic             err_ovf
`endif
);

    localparam int unsigned CW = $clog2(NB);
    localparam logic [CW-1:0] CntLast = CW'(NB - 1);

    logic [NB*DW-1:0] data_buf, data_buf_d;
    logic             valid, valid_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [7:0]       mode_r, mode_r_d;

    logic last_beat;
    logic i_xfer;
    logic t_xfer;
    logic cfg_xfer;

    // Only bit0 of the mode byte is meaningful here; the rest is carried for the defunnel.
    logic unused_mode;
    assign unused_mode = ^mode_r[7:1];

    always_comb begin
        last_beat = mode_r[0] ? (cnt == CntLast) : 1'b1;
        i_0_req   = valid;
        i_xfer    = valid & i_0_ack;
        i_0_data  = data_buf[cnt*DW +: DW];
        enable    = {NB{i_xfer}} & (NB'(1'b1) << cnt);
        t_cfg_ack = ~reset & ~valid;
        // Accepting on the last beat's transfer gives zero-bubble back-to-back words.
        t_0_ack   = ~reset & ~t_cfg_req & (~valid | (i_xfer & last_beat));
        t_xfer    = t_0_req & t_0_ack;
        cfg_xfer  = t_cfg_req & t_cfg_ack;
    end

    always_comb begin
        data_buf_d = data_buf;
        valid_d    = valid;
        cnt_d      = cnt;
        mode_r_d   = mode_r;
        if (i_xfer) begin
            if (last_beat) begin
                cnt_d   = '0;
                valid_d = 1'b0;
            end else begin
                cnt_d = cnt + 1'b1;
            end
        end
        // A load in the same cycle as the last beat overrides the drain.
        if (t_xfer) begin
            data_buf_d = t_0_data;
            valid_d    = 1'b1;
            cnt_d      = '0;
        end
        if (cfg_xfer) begin
            mode_r_d = mode;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_buf <= '0;
            valid    <= 1'b0;
            cnt      <= '0;
            mode_r   <= 8'h01;
        end else begin
            data_buf <= data_buf_d;
            valid    <= valid_d;
            cnt      <= cnt_d;
            mode_r   <= mode_r_d;
        end
    end

`ifdef FUNNEL_CTRL_LAST_EN
    logic [7:0] stall_cnt;

    assign i_0_last = i_0_req & last_beat;

    // stall_cnt saturates at 255; a further stalled cycle means more than 255 in a row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            err_ovf   <= 1'b0;
        end else begin
            if (t_xfer || !t_0_req) begin
                stall_cnt <= '0;
            end else if (stall_cnt != 8'hFF) begin
                stall_cnt <= stall_cnt + 8'd1;
            end
            if (t_0_req && !t_0_ack && stall_cnt == 8'hFF) begin
                err_ovf <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_funnel_ctrl_1_2.sv
// Directed bench for funnel_ctrl_1_2 (DW=8, NB=2) with a beat scoreboard.
// Define FUNNEL_CTRL_LAST_EN to also check i_0_last and err_ovf.
module tb_funnel_ctrl_1_2;

    localparam int unsigned DW = 8;
    localparam int unsigned NB = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             t_0_req;
    logic             t_0_ack;
    logic [NB*DW-1:0] t_0_data;
    logic             t_cfg_req;
    logic             t_cfg_ack;
    logic [7:0]       mode;
    logic             i_0_req;
    logic             i_0_ack;
    logic [DW-1:0]    i_0_data;
    logic [NB-1:0]    enable;
`ifdef FUNNEL_CTRL_LAST_EN
    logic             i_0_last;
    logic             err_ovf;
`endif

    funnel_ctrl_1_2 #(.DW(DW), .NB(NB)) dut (
        .clk       (clk),
        .reset     (reset),
        .t_0_req   (t_0_req),
        .t_0_ack   (t_0_ack),
        .t_0_data  (t_0_data),
        .t_cfg_req (t_cfg_req),
        .t_cfg_ack (t_cfg_ack),
        .mode      (mode),
        .i_0_req   (i_0_req),
        .i_0_ack   (i_0_ack),
        .i_0_data  (i_0_data),
        .enable    (enable)
`ifdef FUNNEL_CTRL_LAST_EN
        ,
        .i_0_last  (i_0_last),
        .err_ovf   (err_ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] en;
        logic       last;
    } beat_t;

    beat_t sb[$];
    beat_t mon_e;
    int    n_assert = 0;
    int    n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void push(input logic [15:0] w, input bit split);
        if (split) begin
            sb.push_back('{d: w[7:0], en: 2'b01, last: 1'b0});
            sb.push_back('{d: w[15:8], en: 2'b10, last: 1'b1});
        end else begin
            sb.push_back('{d: w[7:0], en: 2'b01, last: 1'b1});
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic cfg(input logic [7:0] m);
        t_cfg_req = 1'b1;
        mode      = m;
        at_neg();
        tick();
        t_cfg_req = 1'b0;
    endtask

    // Every narrow transfer pops one expected beat.
    always @(negedge clk) begin
        if (!reset && i_0_req && i_0_ack) begin
            chk("sb_has_entry", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("beat_data", 32'(i_0_data), 32'(mon_e.d));
                chk("beat_enable", 32'(enable), 32'(mon_e.en));
`ifdef FUNNEL_CTRL_LAST_EN
                chk("beat_last", 32'(i_0_last), 32'(mon_e.last));
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        t_0_req   = 1'b0;
        t_0_data  = '0;
        t_cfg_req = 1'b0;
        mode      = 8'h00;
        i_0_ack   = 1'b0;
        #1 reset = 1'b1;

        at_neg();
        chk("rst_i_0_req", 32'(i_0_req), 0);
        chk("rst_t_0_ack", 32'(t_0_ack), 0);
        chk("rst_cfg_ack", 32'(t_cfg_ack), 0);
        chk("rst_enable", 32'(enable), 0);
        chk("rst_data", 32'(i_0_data), 0);
        tick();
        reset = 1'b0;
        at_neg();
        chk("idle_cfg_ack", 32'(t_cfg_ack), 1);
        tick();

        // Split mode, back-to-back words.
        i_0_ack = 1'b1;
        t_0_req = 1'b1; t_0_data = 16'hA55A; push(16'hA55A, 1);
        at_neg(); chk("t1_ack_idle", 32'(t_0_ack), 1); tick();
        t_0_data = 16'h1234; push(16'h1234, 1);
        at_neg(); chk("t1_ack_beat1", 32'(t_0_ack), 0); chk("t1_req_beat1", 32'(i_0_req), 1); tick();
        at_neg(); chk("t1_ack_beat2", 32'(t_0_ack), 1); tick();
        t_0_req = 1'b0;
        at_neg(); chk("t1_ack_beat3", 32'(t_0_ack), 0); chk("t1_req_beat3", 32'(i_0_req), 1); tick();
        at_neg(); chk("t1_ack_beat4", 32'(t_0_ack), 1); tick();
        at_neg(); chk("t1_idle", 32'(i_0_req), 0); tick();

        // Backpressure after the first beat.
        t_0_req = 1'b1; t_0_data = 16'hA55A; push(16'hA55A, 1);
        at_neg(); chk("t2_ack_idle", 32'(t_0_ack), 1); tick();
        t_0_data = 16'h1234; push(16'h1234, 1);
        at_neg(); chk("t2_ack_beat1", 32'(t_0_ack), 0); tick();
        i_0_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("t2_hold_data", 32'(i_0_data), 32'h A5);
            chk("t2_hold_ack", 32'(t_0_ack), 0);
            chk("t2_hold_en", 32'(enable), 0);
            tick();
        end
        i_0_ack = 1'b1;
        at_neg(); chk("t2_resume_ack", 32'(t_0_ack), 1); tick();
        t_0_req = 1'b0;
        at_neg(); tick();
        at_neg(); tick();
        at_neg(); chk("t2_idle", 32'(i_0_req), 0); tick();

        // Bypass mode.
        t_cfg_req = 1'b1; mode = 8'h00;
        at_neg(); chk("t3_cfg_ack", 32'(t_cfg_ack), 1); chk("t3_cfg_blocks", 32'(t_0_ack), 0); tick();
        t_cfg_req = 1'b0;
        t_0_req = 1'b1; t_0_data = 16'hBEEF; push(16'hBEEF, 0);
        at_neg(); chk("t3_ack_idle", 32'(t_0_ack), 1); tick();
        t_0_data = 16'hCAFE; push(16'hCAFE, 0);
        at_neg(); chk("t3_ack_b2b", 32'(t_0_ack), 1); tick();
        t_0_req = 1'b0;
        at_neg(); chk("t3_req_fe", 32'(i_0_req), 1); tick();
        at_neg(); chk("t3_idle", 32'(i_0_req), 0); tick();

        // Config request while a word is in flight.
        cfg(8'h01);
        i_0_ack = 1'b0;
        t_0_req = 1'b1; t_0_data = 16'hA55A; push(16'hA55A, 1);
        at_neg(); chk("t4_ack_idle", 32'(t_0_ack), 1); tick();
        t_0_data = 16'h1234; t_cfg_req = 1'b1; mode = 8'h00;
        at_neg(); chk("t4_cfg_busy0", 32'(t_cfg_ack), 0); chk("t4_ack_busy0", 32'(t_0_ack), 0); tick();
        i_0_ack = 1'b1;
        at_neg(); chk("t4_cfg_busy1", 32'(t_cfg_ack), 0); chk("t4_ack_busy1", 32'(t_0_ack), 0); tick();
        at_neg(); chk("t4_cfg_busy2", 32'(t_cfg_ack), 0); chk("t4_cfg_blocks", 32'(t_0_ack), 0); tick();
        at_neg(); chk("t4_cfg_ack", 32'(t_cfg_ack), 1); chk("t4_ack_cfg", 32'(t_0_ack), 0);
        chk("t4_drained", 32'(i_0_req), 0); tick();
        t_cfg_req = 1'b0; push(16'h1234, 0);
        at_neg(); chk("t4_ack_after_cfg", 32'(t_0_ack), 1); tick();
        t_0_req = 1'b0;
        at_neg(); chk("t4_bypass_beat", 32'(i_0_req), 1); tick();
        at_neg(); chk("t4_bypass_one_beat", 32'(i_0_req), 0); tick();

        // Reset in the middle of a word.
        cfg(8'h01);
        t_0_req = 1'b1; t_0_data = 16'hA55A; push(16'hA55A, 1);
        at_neg(); tick();
        t_0_req = 1'b0;
        at_neg(); tick();
        reset = 1'b1;
        #1;
        chk("t5_rst_req", 32'(i_0_req), 0);
        chk("t5_rst_ack", 32'(t_0_ack), 0);
        chk("t5_rst_cfg", 32'(t_cfg_ack), 0);
        chk("t5_rst_en", 32'(enable), 0);
        chk("t5_rst_data", 32'(i_0_data), 0);
        sb.delete();
        at_neg(); tick();
        reset = 1'b0;
        t_0_req = 1'b1; t_0_data = 16'h1234; push(16'h1234, 1);
        at_neg(); chk("t5_ack_after_rst", 32'(t_0_ack), 1); tick();
        t_0_req = 1'b0;
        at_neg(); chk("t5_cnt0_data", 32'(i_0_data), 32'h34); tick();
        at_neg(); tick();
        at_neg(); chk("t5_idle", 32'(i_0_req), 0); tick();

        // Reset restores split mode after bypass was configured.
        cfg(8'h00);
        reset = 1'b1; at_neg(); tick(); reset = 1'b0;
        t_0_req = 1'b1; t_0_data = 16'hBEEF; push(16'hBEEF, 1);
        at_neg(); tick();
        t_0_req = 1'b0;
        at_neg(); tick();
        at_neg(); chk("t6_split_second", 32'(i_0_req), 1); tick();
        at_neg(); chk("t6_idle", 32'(i_0_req), 0); tick();

`ifdef FUNNEL_CTRL_LAST_EN
        // Input held stalled: err_ovf sets on the 256th stalled cycle and sticks.
        i_0_ack = 1'b0;
        t_0_req = 1'b1; t_0_data = 16'hA55A; push(16'hA55A, 1);
        at_neg(); chk("t7_ack_idle", 32'(t_0_ack), 1); tick();
        t_0_data = 16'h1234;
        for (int i = 0; i < 256; i++) begin
            at_neg();
            if (i == 255) chk("t7_err_before", 32'(err_ovf), 0);
            tick();
        end
        at_neg(); chk("t7_err_set", 32'(err_ovf), 1); tick();
        t_0_req = 1'b0;
        at_neg(); chk("t7_err_sticky", 32'(err_ovf), 1); tick();
        reset = 1'b1;
        #1 chk("t7_err_rst", 32'(err_ovf), 0);
        sb.delete();
        at_neg(); tick();
        reset = 1'b0; i_0_ack = 1'b1;
        tick();
`endif

        chk("sb_drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/funnel_ctrl_1_2.md
Name: funnel_ctrl_1_2

Overview:
- Wide-to-narrow serializer control plus datapath: accepts one NB*DW-bit word per handshake and emits it as NB consecutive DW-bit beats, LSB slice first.
- Sits directly upstream of the 2:1 defunnel control. Its narrow output feeds that stage's narrow input, so a funnel/defunnel pair round-trips a wide word across a narrow link.
- Same mode-byte convention as the defunnel. Mode is latched through a config handshake and changes only between words.

Parameters:
- DW, 32, narrow beat width in bits
- NB, 2, beats per wide word (>= 2); counter width is clog2(NB)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- t_0_req  input  1  wide word valid
- t_0_ack  output  1  wide word accepted (transfer = t_0_req & t_0_ack)
- t_0_data  input  NB*DW  wide word; beat k = bits [k*DW +: DW]
- t_cfg_req  input  1  config update request
- t_cfg_ack  output  1  config accepted
- mode  input  8  config byte, sampled on config transfer; bit0 = split enable
- i_0_req  output  1  narrow beat valid
- i_0_ack  input  1  downstream ready (transfer = i_0_req & i_0_ack)
- i_0_data  output  DW  current narrow beat
- enable  output  NB  one-hot beat index, gated by narrow transfer

Behaviour:
- Handshakes:
  - Transfer occurs when req & ack are high in the same cycle.
  - Once raised, a req is held with its data stable until acked.
  - i_0_req never depends combinationally on i_0_ack.
- State:
  - buf (NB*DW), valid (1), cnt (clog2(NB)), mode_r (8).
  - Reset values: valid=0, cnt=0, buf=0, mode_r=8'h01.
  - Outputs under reset: i_0_req=0, i_0_data=0, enable=0, t_0_ack=0, t_cfg_ack=0.
- last_beat:
  - mode_r[0]=1: last_beat = (cnt==NB-1).
  - mode_r[0]=0 (bypass): last_beat = 1. Only slice 0 of each word is emitted; the other slices are discarded.
- Outputs:
  - i_0_req = valid.
  - i_0_data = buf[cnt*DW +: DW].
  - enable = {NB{i_0_req & i_0_ack}} & (1 << cnt).
- Accept rule:
  - t_0_ack = ~reset & ~t_cfg_req & (~valid | (i_0_req & i_0_ack & last_beat)).
  - This gives zero-bubble back-to-back words: the last beat of word N and the load of word N+1 happen in the same cycle.
- Load: on t transfer, buf <= t_0_data, valid <= 1, cnt <= 0.
- Advance: on i transfer with ~last_beat, cnt <= cnt+1.
- Last beat: on i transfer with last_beat, cnt <= 0 and valid <= 0, unless a load happens in the same cycle (the load wins, valid stays 1).
- Stall: if i_0_req & ~i_0_ack, buf, cnt and valid hold.
- Config:
  - t_cfg_ack = ~reset & ~valid.
  - On config transfer, mode_r <= mode; the new mode applies from the next cycle.
  - Config has priority over data: a pending t_cfg_req blocks t_0_ack, so a mode change can never land mid-word.
- Throughput:
  - Split mode: 1 wide word per NB cycles at full downstream rate.
  - Bypass mode: 1 per cycle.
- Latency: first beat is valid the cycle after the word is accepted.
- Reset mid-word: the partially sent word is dropped and cnt returns to 0. No beat is replayed after reset release.

Optional Feature:
- Macro: FUNNEL_CTRL_LAST_EN.
- Defined:
  - Adds output port i_0_last (1 bit) = i_0_req & last_beat.
  - Adds sticky output err_ovf (1 bit), reset 0. It sets when t_0_req is held high for more than 255 consecutive cycles without ack.
  - The stall counter is 8 bits, saturating, and clears on t transfer or when t_0_req drops.
- Undefined: neither port nor the counter exists. All other behaviour is identical.

Test Plan:
- Split mode, DW=8, NB=2, i_0_ack=1: send 16'hA55A then 16'h1234 back-to-back.
  - Beats are 5A, A5, 34, 12 on consecutive cycles.
  - t_0_ack is high on the cycles of beats 2 and 4 (zero bubble).
  - enable is 01, 10, 01, 10.
- Backpressure: i_0_ack low for 3 cycles mid-word (after beat 5A).
  - i_0_data holds A5 and t_0_ack stays 0.
  - A5 transfers on the first ack cycle, and word 2 loads in that same cycle.
- Bypass: config mode=8'h00 while idle, then send 16'hBEEF and 16'hCAFE.
  - Exactly two beats are emitted: EF then FE, one per cycle.
- Config while busy: assert t_cfg_req=1 with mode=8'h00 while beat 1 is pending.
  - t_cfg_ack stays 0 until the word drains.
  - t_0_ack stays 0 while t_cfg_req is high.
  - mode_r changes the cycle after the ack.
- Reset mid-word: assert reset after beat 5A.
  - i_0_req drops immediately; after release, the next word starts at cnt=0 and mode_r=8'h01.
- FUNNEL_CTRL_LAST_EN:
  - i_0_last is high on beats A5 and 12 only.
  - Holding t_0_req high for 256 stalled cycles sets err_ovf, which stays 1 until reset.
